mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Multi-channel memory port arbiter: one outstanding data-cache transaction at a time,
// round-robin or fixed-priority grant, flush-aware read delivery.
//
// state | meaning
// IDLE  | no transaction; sample requests and register the winner's command
// BUSY  | command held on mem_*; waiting for mem_resp
// DRAIN | flushed read still in flight; response is swallowed when it arrives
module mem_port_arbiter #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RR_EN  = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [NUM_CH-1:0]          ch_read,
  input  logic [NUM_CH-1:0]          ch_write,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
  input  logic [NUM_CH*DATA_W/8-1:0] ch_byte_enable,
  output logic [NUM_CH-1:0]          ch_resp,
  output logic [DATA_W-1:0]          ch_rdata,
  input  logic                       mem_resp,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [ADDR_W-1:0]          mem_address,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic [DATA_W/8-1:0]        mem_byte_enable
);

  localparam int BE_W = DATA_W / 8;
  localparam int CH_W = $clog2(NUM_CH);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DRAIN = 2'd2} state_t;

  state_t            r_state;
  logic [CH_W-1:0]   r_rr_ptr;
  logic [CH_W-1:0]   r_winner;
  logic              r_is_write;

  logic [NUM_CH-1:0] w_req;
  logic              w_any;
  logic [CH_W-1:0]   w_grant;
  logic              w_suppress;
  logic [CH_W-1:0]   w_ptr_next;

  function automatic logic [CH_W-1:0] scan_idx(input logic [CH_W-1:0] base, input int k);
    int s;
    s = (RR_EN != 0) ? (int'(base) + k) % NUM_CH : k;
    return CH_W'(s);
  endfunction

  // Under flush only writes may start; reads are held off until flush drops.
  assign w_req      = flush ? ch_write : (ch_read | ch_write);
  assign w_suppress = flush & ~r_is_write;
  assign w_ptr_next = (r_winner == CH_W'(NUM_CH - 1)) ? '0 : r_winner + CH_W'(1);

  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!w_any && w_req[scan_idx(r_rr_ptr, k)]) begin
        w_any   = 1'b1;
        w_grant = scan_idx(r_rr_ptr, k);
      end
    end
  end

  // Completion must land in the same cycle as mem_resp, so it is decoded here.
  always_comb begin
    ch_resp  = '0;
    ch_rdata = '0;
    if (r_state == BUSY && mem_resp && !w_suppress) begin
      ch_resp[r_winner] = 1'b1;
      ch_rdata          = mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= IDLE;
      r_rr_ptr        <= '0;
      r_winner        <= '0;
      r_is_write      <= 1'b0;
      mem_read        <= 1'b0;
      mem_write       <= 1'b0;
      mem_address     <= '0;
      mem_wdata       <= '0;
      mem_byte_enable <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_winner        <= w_grant;
            r_is_write      <= ch_write[w_grant];
            mem_read        <= ~ch_write[w_grant];
            mem_write       <= ch_write[w_grant];
            mem_address     <= ch_addr[w_grant*ADDR_W +: ADDR_W];
            mem_wdata       <= ch_wdata[w_grant*DATA_W +: DATA_W];
            mem_byte_enable <= ch_byte_enable[w_grant*BE_W +: BE_W];
            r_state         <= BUSY;
          end
        end
        BUSY: begin
          if (mem_resp) begin
            r_state   <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            r_rr_ptr  <= w_ptr_next;
          end else if (w_suppress) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (mem_resp) begin
            r_state   <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            r_rr_ptr  <= w_ptr_next;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table plus hand sequences, with a command/response
// scoreboard fed by the driver and drained by a negedge monitor.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [1:0]  ch_read, ch_write;
  logic [63:0] ch_addr, ch_wdata;
  logic [7:0]  ch_byte_enable;
  logic        mem_resp;
  logic [31:0] mem_rdata;

  logic [1:0]  ch_resp, b_ch_resp;
  logic [31:0] ch_rdata, b_ch_rdata;
  logic        mem_read, mem_write, b_mem_read, b_mem_write;
  logic [31:0] mem_address, mem_wdata, b_mem_address, b_mem_wdata;
  logic [3:0]  mem_byte_enable, b_mem_byte_enable;

  localparam logic [31:0] IDLE_RDATA = 32'hCAFEF00D;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .RR_EN(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .ch_read(ch_read), .ch_write(ch_write),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_byte_enable(ch_byte_enable),
    .ch_resp(ch_resp), .ch_rdata(ch_rdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable)
  );

  mem_port_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .RR_EN(0)) dut_fixed (
    .clk(clk), .rst(rst), .flush(flush), .ch_read(ch_read), .ch_write(ch_write),
    .ch_addr(ch_addr), .ch_wdata(ch_wdata), .ch_byte_enable(ch_byte_enable),
    .ch_resp(b_ch_resp), .ch_rdata(b_ch_rdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .mem_address(b_mem_address),
    .mem_wdata(b_mem_wdata), .mem_byte_enable(b_mem_byte_enable)
  );

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } cmd_t;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] rdata;
  } resp_t;

  typedef struct {
    logic [1:0]  rd, wr;
    logic        fl;
    logic [31:0] a0, a1, d0, d1;
    logic [3:0]  b0, b1;
    logic [31:0] rdat;
    int          lat;
    cmd_t        e_cmd;
    logic [1:0]  e_resp;
  } vec_t;

  cmd_t  cmd_q[$];
  resp_t resp_q[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be);
    cmd_t c;
    c.rd = rd; c.wr = wr; c.addr = a; c.wdata = d; c.be = be;
    cmd_q.push_back(c);
  endtask

  task automatic push_resp(input logic [1:0] r, input logic [31:0] d);
    resp_t e;
    e.resp = r; e.rdata = d;
    resp_q.push_back(e);
  endtask

  task automatic monitor();
    logic  p_cmd;
    cmd_t  p_val, cur, e;
    resp_t er;
    p_cmd = 1'b0;
    p_val = '0;
    forever begin
      @(negedge clk);
      cur = {mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable};
      if ((mem_read | mem_write) && !p_cmd) begin
        if (cmd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cmd_unexpected actual=%0h required=none", cur);
        end else begin
          e = cmd_q.pop_front();
          chk("cmd", 128'(cur), 128'(e));
        end
      end else if ((mem_read | mem_write) && p_cmd) begin
        chk("cmd_stable", 128'(cur), 128'(p_val));
      end
      if (ch_resp != 2'b00) begin
        if (resp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp_unexpected actual=%0h required=none", ch_resp);
        end else begin
          er = resp_q.pop_front();
          chk("resp", {ch_resp, ch_rdata}, 128'(er));
        end
      end
      chk("resp_onehot", 128'($countones(ch_resp) <= 1), 128'(1));
      if (ch_resp == 2'b00) chk("rdata_zero", 128'(ch_rdata), 128'(0));
      p_cmd = mem_read | mem_write;
      p_val = cur;
    end
  endtask

  task automatic wait_cmd(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mem_read | mem_write) && n < 20);
    if (!(mem_read | mem_write)) begin
      checks++; errors++;
      $display("FAIL wait_cmd actual=timeout required=command within 20 cycles");
    end
  endtask

  task automatic clear_reqs();
    ch_read = 2'b00; ch_write = 2'b00; flush = 1'b0;
    mem_resp = 1'b0; mem_rdata = IDLE_RDATA;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  vec_t vecs[8];

  initial begin
    int n;
    logic [31:0] rr_data;

    // Expected winners follow the RR pointer left by the preceding step (0 after the RR sequence).
    vecs[0] = '{2'b10, 2'b00, 1'b0, 32'h10, 32'h100, 32'hA0A0A0A0, 32'hB1B1B1B1, 4'hF, 4'h3,
                32'hDEADBEEF, 2, {1'b1, 1'b0, 32'h100, 32'hB1B1B1B1, 4'h3}, 2'b10};
    vecs[1] = '{2'b11, 2'b00, 1'b0, 32'h20, 32'h120, 32'h11111111, 32'h22222222, 4'hF, 4'hC,
                32'h0BADF00D, 1, {1'b1, 1'b0, 32'h20, 32'h11111111, 4'hF}, 2'b01};
    vecs[2] = '{2'b11, 2'b00, 1'b0, 32'h24, 32'h124, 32'h33333333, 32'h44444444, 4'h1, 4'h8,
                32'h13579BDF, 0, {1'b1, 1'b0, 32'h124, 32'h44444444, 4'h8}, 2'b10};
    vecs[3] = '{2'b01, 2'b10, 1'b1, 32'h50, 32'h40, 32'h66666666, 32'h12345678, 4'hF, 4'h3,
                32'h89ABCDEF, 2, {1'b0, 1'b1, 32'h40, 32'h12345678, 4'h3}, 2'b10};
    vecs[4] = '{2'b01, 2'b01, 1'b0, 32'h30, 32'h130, 32'hCAFEBABE, 32'h55555555, 4'h6, 4'hF,
                32'h77777777, 1, {1'b0, 1'b1, 32'h30, 32'hCAFEBABE, 4'h6}, 2'b01};
    vecs[5] = '{2'b10, 2'b01, 1'b0, 32'h60, 32'h160, 32'h0F0F0F0F, 32'hF0F0F0F0, 4'hF, 4'hF,
                32'h2468ACE0, 1, {1'b1, 1'b0, 32'h160, 32'hF0F0F0F0, 4'hF}, 2'b10};
    vecs[6] = '{2'b00, 2'b10, 1'b0, 32'h70, 32'h170, 32'h01020304, 32'hA5A5A5A5, 4'hF, 4'h9,
                32'h31415926, 0, {1'b0, 1'b1, 32'h170, 32'hA5A5A5A5, 4'h9}, 2'b10};
    vecs[7] = '{2'b01, 2'b00, 1'b0, 32'h80, 32'h180, 32'hFFFFFFFF, 32'h00000000, 4'h2, 4'h0,
                32'hFEEDFACE, 3, {1'b1, 1'b0, 32'h80, 32'hFFFFFFFF, 4'h2}, 2'b01};

    rst = 1'b0;
    clear_reqs();
    ch_addr = '0; ch_wdata = '0; ch_byte_enable = '0;
    mem_resp = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_mem_read", 128'(mem_read), 128'(0));
    chk("rst_mem_write", 128'(mem_write), 128'(0));
    chk("rst_mem_address", 128'(mem_address), 128'(0));
    chk("rst_mem_wdata", 128'(mem_wdata), 128'(0));
    chk("rst_mem_be", 128'(mem_byte_enable), 128'(0));
    chk("rst_ch_resp", 128'(ch_resp), 128'(0));
    chk("rst_ch_rdata", 128'(ch_rdata), 128'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    mem_resp = 1'b0;
    fork monitor(); join_none

    // Both channels reading continuously: RR alternates, fixed priority sticks to ch0.
    ch_read = 2'b11;
    ch_addr = {32'h2000, 32'h1000};
    ch_wdata = {32'h0000BBBB, 32'h0000AAAA};
    ch_byte_enable = {4'hC, 4'h5};
    for (int k = 0; k < 4; k++) begin
      rr_data = 32'h10000000 + 32'(k);
      if (k % 2 == 0) begin
        push_cmd(1'b1, 1'b0, 32'h1000, 32'h0000AAAA, 4'h5);
        push_resp(2'b01, rr_data);
      end else begin
        push_cmd(1'b1, 1'b0, 32'h2000, 32'h0000BBBB, 4'hC);
        push_resp(2'b10, rr_data);
      end
    end
    for (int k = 0; k < 4; k++) begin
      rr_data = 32'h10000000 + 32'(k);
      wait_cmd(n);
      chk("fixed_grant", {b_mem_read, b_mem_write, b_mem_address, b_mem_wdata, b_mem_byte_enable},
          {1'b1, 1'b0, 32'h1000, 32'h0000AAAA, 4'h5});
      @(posedge clk); #1;
      mem_resp = 1'b1; mem_rdata = rr_data;
      @(negedge clk);
      chk("fixed_resp", {b_ch_resp, b_ch_rdata}, {2'b01, rr_data});
      @(posedge clk); #1;
      mem_resp = 1'b0; mem_rdata = IDLE_RDATA;
      if (k == 3) clear_reqs();
    end

    for (int i = 0; i < 8; i++) begin
      ch_read = vecs[i].rd; ch_write = vecs[i].wr; flush = vecs[i].fl;
      ch_addr = {vecs[i].a1, vecs[i].a0};
      ch_wdata = {vecs[i].d1, vecs[i].d0};
      ch_byte_enable = {vecs[i].b1, vecs[i].b0};
      cmd_q.push_back(vecs[i].e_cmd);
      push_resp(vecs[i].e_resp, vecs[i].rdat);
      wait_cmd(n);
      chk("grant_latency", 128'(n), 128'(2));
      repeat (vecs[i].lat) @(posedge clk);
      @(posedge clk); #1;
      mem_resp = 1'b1; mem_rdata = vecs[i].rdat;
      @(posedge clk); #1;
      clear_reqs();
    end

    // Flush coinciding with the response of a read: nothing delivered.
    ch_read = 2'b10; ch_addr = {32'h400, 32'h0}; ch_wdata = {32'h4444, 32'h0};
    ch_byte_enable = {4'hF, 4'h0};
    push_cmd(1'b1, 1'b0, 32'h400, 32'h4444, 4'hF);
    wait_cmd(n);
    @(posedge clk); #1;
    flush = 1'b1; mem_resp = 1'b1; mem_rdata = 32'h0DDBA11;
    @(negedge clk);
    chk("flush_resp_suppressed", 128'(ch_resp), 128'(0));
    @(posedge clk); #1;
    clear_reqs();
    @(negedge clk);
    chk("flush_resp_idle", 128'({mem_read, mem_write}), 128'(0));
    @(posedge clk); #1;

    // Flush during a read: drain, mem_read held, response swallowed.
    ch_read = 2'b01; ch_addr = {32'h0, 32'h300}; ch_wdata = {32'h0, 32'h3333};
    ch_byte_enable = {4'h0, 4'hF};
    push_cmd(1'b1, 1'b0, 32'h300, 32'h3333, 4'hF);
    wait_cmd(n);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; ch_read = 2'b00;
    @(negedge clk);
    chk("drain_hold", 128'({mem_read, mem_write, mem_address}), {1'b1, 1'b0, 32'h300});
    @(posedge clk); #1;
    mem_resp = 1'b1; mem_rdata = 32'h55AA55AA;
    @(negedge clk);
    chk("drain_no_resp", 128'(ch_resp), 128'(0));
    @(posedge clk); #1;
    clear_reqs();
    @(negedge clk);
    chk("drain_exit", 128'({mem_read, mem_write}), 128'(0));
    @(posedge clk); #1;

    // Reset while a ch1 write is outstanding (RR pointer is 1 here).
    ch_write = 2'b10; ch_addr = {32'h80, 32'h900}; ch_wdata = {32'h9ABCDEF0, 32'h0};
    ch_byte_enable = {4'hF, 4'h0};
    push_cmd(1'b0, 1'b1, 32'h80, 32'h9ABCDEF0, 4'hF);
    wait_cmd(n);
    @(posedge clk); #1;
    rst = 1'b0; mem_resp = 1'b1; mem_rdata = 32'h13131313;
    #2;
    chk("rst_mid_outputs", {mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable},
        128'(0));
    chk("rst_mid_resp", {ch_resp, ch_rdata}, 128'(0));
    ch_write = 2'b00;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    mem_resp = 1'b0; mem_rdata = IDLE_RDATA;
    @(negedge clk);
    chk("stray_resp_ignored", 128'({mem_read, mem_write, ch_resp}), 128'(0));
    @(posedge clk); #1;
    ch_read = 2'b11; ch_addr = {32'hA00, 32'h900}; ch_wdata = {32'h2, 32'h1};
    ch_byte_enable = {4'h8, 4'h1};
    push_cmd(1'b1, 1'b0, 32'h900, 32'h1, 4'h1);
    push_resp(2'b01, 32'h600DCAFE);
    wait_cmd(n);
    chk("rr_after_reset", 128'(mem_address), 128'(32'h900));
    @(posedge clk); #1;
    mem_resp = 1'b1; mem_rdata = 32'h600DCAFE;
    @(posedge clk); #1;
    clear_reqs();

    repeat (3) @(posedge clk);
    #1;
    chk("cmd_q_drained", 128'(cmd_q.size()), 128'(0));
    chk("resp_q_drained", 128'(resp_q.size()), 128'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
